// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and frame-length helper for the UART transmitter
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits);
    return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - queued UART transmitter with configurable data width, parity and stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [CW-1:0]         baud_cnt;
  logic [CW-1:0]         baud_next;
  logic [BW-1:0]         bit_idx;
  logic [BW-1:0]         bit_next;
  logic                  stop_idx;
  logic                  stop_next;
  logic [DATA_BITS-1:0]  shift;
  logic [DATA_BITS-1:0]  shift_next;
  logic                  par_bit;
  logic                  par_next;
  logic                  bit_done;
  logic                  can_start;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_head;

  // wr_ready comes from the registered count only, so a same-cycle pop never frees a slot
  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign bit_done  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign can_start = !fifo_empty && ena;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     overflow <= 1'b0;
    else if (wr_valid && fifo_full) overflow <= 1'b1;
    else if (clr_ovf)               overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != ST_IDLE);
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      stop_idx <= stop_next;
      shift    <= shift_next;
      par_bit  <= par_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = bit_done ? '0 : baud_cnt + CW'(1);
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    shift_next = shift;
    par_next   = par_bit;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_next = '0;
        if (can_start) begin
          state_next = ST_START;
          pop        = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = shift >> 1;
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            stop_next  = 1'b0;
          end else begin
            bit_next = bit_idx + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_next = ST_STOP;
          stop_next  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            if (can_start) begin
              state_next = ST_START;
              pop        = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            stop_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // The frame owns its own copy of the data so later FIFO writes cannot disturb it
    if (pop) begin
      shift_next = fifo_head;
      par_next   = (^fifo_head) ^ (PARITY == PAR_ODD);
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift[0];
      ST_PARITY: tx = par_bit;
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo; three instances cover none/even/odd parity
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int C       = 100;
  localparam int CAP_MAX = 4 * frame_cycles(C, 8, PAR_EVEN, 2) + 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       wr_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       tx_m, busy_m, wr_ready_m, overflow_m;
  logic [2:0] fifo_count_m;
  logic       tx_e, busy_e, wr_ready_e, overflow_e;
  logic [2:0] fifo_count_e;
  logic       tx_o, busy_o, wr_ready_o, overflow_o;
  logic [2:0] fifo_count_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];
  logic       cap0[$];
  logic       cap1[$];
  logic       cap2[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut_m (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_m), .tx(tx_m), .busy(busy_m), .fifo_count(fifo_count_m),
    .overflow(overflow_m), .clr_ovf(clr_ovf)
  );

  uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_e), .tx(tx_e), .busy(busy_e), .fifo_count(fifo_count_e),
    .overflow(overflow_e), .clr_ovf(clr_ovf)
  );

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_o), .tx(tx_o), .busy(busy_o), .fifo_count(fifo_count_o),
    .overflow(overflow_o), .clr_ovf(clr_ovf)
  );

  function automatic logic tx_of(input int w);
    case (w)
      0:       return tx_m;
      1:       return tx_e;
      default: return tx_o;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_m;
      1:       return busy_e;
      default: return busy_o;
    endcase
  endfunction

  function automatic int cap_size(input int w);
    case (w)
      0:       return cap0.size();
      1:       return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  function automatic logic cap_at(input int w, input int i);
    if (i >= cap_size(w)) return 1'bx;
    case (w)
      0:       return cap0[i];
      1:       return cap1[i];
      default: return cap2[i];
    endcase
  endfunction

  function automatic int sb_size(input int w);
    case (w)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [7:0] sb_pop(input int w);
    case (w)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  // Pops nframes expected bytes and counts per-cycle disagreements with the captured line
  function automatic int wave_errors(input int w, input int nframes);
    int          par;
    int          stops;
    int          idx;
    int          err;
    int          nb;
    logic [7:0]  d;
    logic [12:0] bits;
    par   = w;
    stops = (w == 0) ? 1 : 2;
    idx   = 0;
    err   = 0;
    for (int f = 0; f < nframes; f++) begin
      if (sb_size(w) == 0) begin
        err++;
        break;
      end
      d    = sb_pop(w);
      bits = '0;
      nb   = 1;
      for (int i = 0; i < 8; i++) begin
        bits[nb] = d[i];
        nb++;
      end
      if (par != 0) begin
        bits[nb] = (^d) ^ (par == 2);
        nb++;
      end
      for (int s = 0; s < stops; s++) begin
        bits[nb] = 1'b1;
        nb++;
      end
      for (int b = 0; b < nb; b++)
        for (int c = 0; c < C; c++) begin
          if (cap_at(w, idx) !== bits[b]) err++;
          idx++;
        end
    end
    if (cap_size(w) != idx) err++;
    return err;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b1;
    wr_valid = 1'b0;
    clr_ovf  = 1'b0;
    wr_data  = 8'h00;
    sb0.delete();
    sb1.delete();
    sb2.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] d, input bit accept);
    wr_data  = d;
    wr_valid = 1'b1;
    if (accept) begin
      sb0.push_back(d);
      sb1.push_back(d);
      sb2.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Samples tx at every falling edge from the first low sample until busy drops
  task automatic capture(input int w, output int waited);
    int n;
    case (w)
      0:       cap0.delete();
      1:       cap1.delete();
      default: cap2.delete();
    endcase
    waited = 0;
    n      = 0;
    @(negedge clk);
    while (tx_of(w) === 1'b1 && waited < CAP_MAX) begin
      waited++;
      @(negedge clk);
    end
    while (busy_of(w) === 1'b1 && n < CAP_MAX) begin
      case (w)
        0:       cap0.push_back(tx_of(w));
        1:       cap1.push_back(tx_of(w));
        default: cap2.push_back(tx_of(w));
      endcase
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_m !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_m); end
    checks++; if (wr_ready_m !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready_m); end
    checks++; if (fifo_count_m !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count_m); end
    checks++; if (overflow_m !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_m); end
    checks++;
    if ({tx_e, busy_e, wr_ready_e, fifo_count_e, overflow_e} !== 7'b1010000) begin
      failures++;
      $display("FAIL reset_even got=%b exp=1010000", {tx_e, busy_e, wr_ready_e, fifo_count_e, overflow_e});
    end
    checks++;
    if ({tx_o, busy_o, wr_ready_o, fifo_count_o, overflow_o} !== 7'b1010000) begin
      failures++;
      $display("FAIL reset_odd got=%b exp=1010000", {tx_o, busy_o, wr_ready_o, fifo_count_o, overflow_o});
    end
  endtask

  task automatic test_single();
    int w;
    int e;
    do_reset();
    @(negedge clk);
    do_write(8'h55, 1'b1);
    capture(0, w);
    checks++; if (w !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", w); end
    checks++; if (cap0.size() !== 1000) begin failures++; $display("FAIL single_frame_len got=%0d exp=1000", cap0.size()); end
    e = wave_errors(0, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL single_wave got=%0d bad_cycles exp=0", e); end
    checks++; if (tx_m !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b exp=1", tx_m); end
  endtask

  task automatic test_back_to_back();
    int w;
    int e;
    logic [2:0] cnt;
    do_reset();
    @(negedge clk);
    do_write(8'h55, 1'b1);
    do_write(8'hA5, 1'b1);
    fork
      capture(0, w);
      begin
        @(negedge clk);
        cnt = fifo_count_m;
      end
    join
    checks++; if (cnt !== 3'd1) begin failures++; $display("FAIL b2b_push_pop_count got=%0d exp=1", cnt); end
    checks++; if (w !== 0) begin failures++; $display("FAIL b2b_latency got=%0d exp=0", w); end
    checks++; if (cap0.size() !== 2000) begin failures++; $display("FAIL b2b_len got=%0d exp=2000", cap0.size()); end
    e = wave_errors(0, 2);
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b_wave got=%0d bad_cycles exp=0", e); end
  endtask

  task automatic test_parity();
    int w0;
    int w1;
    int w2;
    int e;
    do_reset();
    @(negedge clk);
    do_write(8'h07, 1'b1);
    fork
      capture(0, w0);
      capture(1, w1);
      capture(2, w2);
    join
    checks++; if (cap1.size() !== 1200) begin failures++; $display("FAIL even_len got=%0d exp=1200", cap1.size()); end
    checks++; if (cap2.size() !== 1200) begin failures++; $display("FAIL odd_len got=%0d exp=1200", cap2.size()); end
    checks++; if (cap_at(1, 950) !== 1'b1) begin failures++; $display("FAIL even_parity_bit got=%b exp=1", cap_at(1, 950)); end
    checks++; if (cap_at(2, 950) !== 1'b0) begin failures++; $display("FAIL odd_parity_bit got=%b exp=0", cap_at(2, 950)); end
    checks++; if (cap_at(1, 1150) !== 1'b1) begin failures++; $display("FAIL even_stop2 got=%b exp=1", cap_at(1, 1150)); end
    e = wave_errors(1, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL even_wave got=%0d bad_cycles exp=0", e); end
    e = wave_errors(2, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL odd_wave got=%0d bad_cycles exp=0", e); end
    e = wave_errors(0, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL none_wave_07 got=%0d bad_cycles exp=0", e); end
  endtask

  task automatic test_overflow();
    int w;
    int e;
    int bad;
    do_reset();
    ena = 1'b0;
    @(negedge clk);
    do_write(8'h11, 1'b1);
    do_write(8'h22, 1'b1);
    do_write(8'h33, 1'b1);
    do_write(8'h44, 1'b1);
    do_write(8'h99, 1'b0);
    @(negedge clk);
    checks++; if (fifo_count_m !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count_m); end
    checks++; if (wr_ready_m !== 1'b0) begin failures++; $display("FAIL ovf_wr_ready got=%b exp=0", wr_ready_m); end
    checks++; if (overflow_m !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_m); end
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    clr_ovf  = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    clr_ovf  = 1'b0;
    @(negedge clk);
    checks++; if (overflow_m !== 1'b1) begin failures++; $display("FAIL ovf_priority got=%b exp=1", overflow_m); end
    ena = 1'b1;
    capture(0, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL ovf_start got=%0d exp=0", w); end
    checks++; if (cap0.size() !== 4000) begin failures++; $display("FAIL ovf_len got=%0d exp=4000", cap0.size()); end
    e = wave_errors(0, 4);
    checks++; if (e !== 0) begin failures++; $display("FAIL ovf_wave got=%0d bad_cycles exp=0", e); end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_no_fifth got=%0d active_cycles exp=0", bad); end
    checks++; if (overflow_m !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_m); end
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    checks++; if (overflow_m !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow_m); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    @(negedge clk);
    do_write(8'h5A, 1'b1);
    do_write(8'hC3, 1'b1);
    repeat (650) @(negedge clk);
    checks++; if (tx_m !== 1'b0) begin failures++; $display("FAIL mid_pre_tx got=%b exp=0", tx_m); end
    checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL mid_pre_busy got=%b exp=1", busy_m); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_m !== 1'b1) begin failures++; $display("FAIL mid_async_tx got=%b exp=1", tx_m); end
    checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", busy_m); end
    checks++; if (fifo_count_m !== 3'd0) begin failures++; $display("FAIL mid_async_count got=%0d exp=0", fifo_count_m); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || fifo_count_m !== 3'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mid_no_frame got=%0d active_cycles exp=0", bad); end
  endtask

  task automatic test_ena_drop();
    int w;
    int e;
    int bad;
    do_reset();
    ena = 1'b0;
    @(negedge clk);
    do_write(8'h3C, 1'b1);
    do_write(8'h81, 1'b1);
    do_write(8'hE7, 1'b1);
    @(negedge clk);
    checks++; if (fifo_count_m !== 3'd3) begin failures++; $display("FAIL ena_queued got=%0d exp=3", fifo_count_m); end
    ena = 1'b1;
    fork
      capture(0, w);
      begin
        repeat (500) @(negedge clk);
        ena = 1'b0;
      end
    join
    checks++; if (cap0.size() !== 1000) begin failures++; $display("FAIL ena_first_len got=%0d exp=1000", cap0.size()); end
    e = wave_errors(0, 1);
    checks++; if (e !== 0) begin failures++; $display("FAIL ena_first_wave got=%0d bad_cycles exp=0", e); end
    checks++; if (fifo_count_m !== 3'd2) begin failures++; $display("FAIL ena_left got=%0d exp=2", fifo_count_m); end
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ena_hold got=%0d active_cycles exp=0", bad); end
    ena = 1'b1;
    capture(0, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL ena_resume got=%0d exp=0", w); end
    checks++; if (cap0.size() !== 2000) begin failures++; $display("FAIL ena_rest_len got=%0d exp=2000", cap0.size()); end
    e = wave_errors(0, 2);
    checks++; if (e !== 0) begin failures++; $display("FAIL ena_rest_wave got=%0d bad_cycles exp=0", e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_overflow();
    test_reset_mid();
    test_ena_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
